// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: the first set request strictly after ptr_i wins,
// wrapping modulo N_REQ.
module rr_priority_select #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            int unsigned cand;
            cand = (32'(ptr_i) + off) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = IDX_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port, with a 32-entry clear sequencer.
// Optional REGFILE_ARB_ZERO_REG_EN: granted writes to register 0 are suppressed.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ*REG_ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]      req_data_i,
    input  logic                         clr_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic                         busy_o,
    output logic                         rf_wr_ena_o,
    output logic [REG_ADDR_W-1:0]        rf_wr_addr_o,
    output logic [DATA_W-1:0]            rf_wr_data_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam arb_state_t  RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

    arb_state_t              state_q, state_d;
    logic [REG_ADDR_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic                    wr_ena_q, wr_ena_d;
    logic [REG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;

    logic [N_REQ-1:0]        sel_gnt;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_valid;
    logic [REG_ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]       sel_data;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_select (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign sel_addr = req_addr_i[sel_idx*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = req_data_i[sel_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        gnt_o     = '0;

        unique case (state_q)
            S_CLEAR: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q == REG_ADDR_W'(REG_COUNT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (clr_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (sel_valid) begin
                    gnt_o     = sel_gnt;
                    ptr_d     = sel_idx;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
`ifdef REGFILE_ARB_ZERO_REG_EN
                    // Register 0 is hard-wired zero; the grant still retires the request.
                    wr_ena_d  = (sel_addr != '0);
`else
                    wr_ena_d  = 1'b1;
`endif
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o       = (state_q == S_CLEAR);
    assign rf_wr_ena_o  = wr_ena_q;
    assign rf_wr_addr_o = wr_addr_q;
    assign rf_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write scoreboard; honours REGFILE_ARB_ZERO_REG_EN.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef REGFILE_ARB_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ena;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*5-1:0]  req_addr;
    logic [N*DW-1:0] req_data;
    logic            clr;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            rf_wr_ena;
    logic [4:0]      rf_wr_addr;
    logic [DW-1:0]   rf_wr_data;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  st_clear;
    int  cnt_m;
    int  ptr_m;

    regfile_write_arbiter #(
        .N_REQ          (N),
        .DATA_W         (DW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .clr_i        (clr),
        .gnt_o        (gnt),
        .busy_o       (busy),
        .rf_wr_ena_o  (rf_wr_ena),
        .rf_wr_addr_o (rf_wr_addr),
        .rf_wr_data_o (rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        st_clear = 1'b1;
        cnt_m    = 0;
        ptr_m    = N - 1;
        exp_q.delete();
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_out();
        wr_t w;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_underflow observed=empty expected=entry");
            return;
        end
        w = exp_q.pop_front();
        chk("wr_ena", rf_wr_ena, w.ena);
        if (w.ena) begin
            chk("wr_addr", rf_wr_addr, w.addr);
            chk("wr_data", rf_wr_data, w.data);
        end
    endtask

    // Drive one cycle at posedge+1, check gnt/busy, predict the registered write, then check it.
    task automatic cyc(input logic [N-1:0] r, input logic c);
        logic [N-1:0] eg;
        wr_t          w;
        int           k;
        req = r;
        clr = c;
        #1;
        eg = '0;
        w  = '0;
        chk("busy", busy, st_clear);
        if (st_clear) begin
            w.ena  = 1'b1;
            w.addr = 5'(cnt_m);
            if (cnt_m == 31) begin
                cnt_m    = 0;
                st_clear = 1'b0;
            end else begin
                cnt_m++;
            end
        end else if (c) begin
            st_clear = 1'b1;
            cnt_m    = 0;
        end else begin
            k = -1;
            for (int o = 1; o <= N; o++) begin
                if (k < 0 && r[(ptr_m + o) % N]) k = (ptr_m + o) % N;
            end
            if (k >= 0) begin
                eg[k]  = 1'b1;
                ptr_m  = k;
                w.addr = req_addr[k*5 +: 5];
                w.data = req_data[k*DW +: DW];
                w.ena  = ZERO_EN ? (w.addr != 5'd0) : 1'b1;
            end
        end
        chk("gnt", gnt, eg);
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        clr      = 1'b0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 8), $urandom);
        set_req(2, 5'd7, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ena", rf_wr_ena, 1'b0);
        chk("rst_addr", rf_wr_addr, 5'd0);
        chk("rst_data", rf_wr_data, 32'd0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b1);
        rst = 1'b0;
        model_reset();

        // Post-reset clear: 32 writes of zero to 0..31, then busy drops.
        for (int i = 0; i < 32; i++) cyc('0, 1'b0);
        #1;
        chk("clear_done_busy", busy, 1'b0);

        // Single requester: same-cycle grant, write one cycle later.
        req = 4'b0100;
        #1;
        chk("t2_gnt", gnt, 4'b0100);
        cyc(4'b0100, 1'b0);
        chk("t2_addr", rf_wr_addr, 5'd7);
        chk("t2_data", rf_wr_data, 32'hDEAD_BEEF);
        cyc('0, 1'b0);

        // All requesting: strict rotation, continuing after last grant (2).
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] one;
            req = 4'b1111;
            #1;
            one = '0;
            one[(3 + i) % N] = 1'b1;
            chk("t3_rot", gnt, one);
            cyc(4'b1111, 1'b0);
        end

        // Clear request interrupts arbitration; it resumes from the saved pointer.
        cyc(4'b1010, 1'b0);
        cyc(4'b1010, 1'b0);
        cyc(4'b1010, 1'b1);
        for (int i = 0; i < 32; i++) cyc(4'b1010, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'b1010, 1'b0);

        // Async reset in the middle of a clear sequence.
        cyc('0, 1'b1);
        for (int i = 0; i < 12; i++) cyc('0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ena", rf_wr_ena, 1'b0);
        chk("mid_rst_addr", rf_wr_addr, 5'd0);
        chk("mid_rst_data", rf_wr_data, 32'd0);
        chk("mid_rst_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) cyc('0, 1'b0);

        // Write to register 0 from requester 0, then confirm the pointer moved past it.
        set_req(0, 5'd0, 32'h1234_5678);
        cyc(4'b0001, 1'b0);
        chk("t6_ena", rf_wr_ena, !ZERO_EN);
        req = 4'b1111;
        #1;
        chk("t6_ptr", gnt, 4'b0010);
        cyc(4'b1111, 1'b0);
        cyc('0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
